// File: rtl/switch_indicator_bank.sv
// ---------------------------------------------------------------------------
// switch_indicator_bank
//
// Draws a row of N_CH square indicator boxes for a bank of switches. Each
// channel latches its switch state once per video frame. After a change, the
// channel blinks for BLINK_FRAMES frames. For every pixel coordinate, the
// block reports whether the pixel is in a visible box, whether that box is
// lit, and which channel it belongs to.
//
// Ports:
//   clk         : single clock; all state updates on its rising edge
//   reset       : synchronous, active-high reset
//   frame_tick  : one-cycle pulse, once per video frame
//   status      : raw switch states, status[i] drives channel i
//   mask        : mask[i]=1 hides channel i (takes effect immediately)
//   x, y        : current pixel coordinate
//   on_group    : registered, pixel lies in a visible box
//   on_lit      : registered, pixel lies in a visible box whose status is 1
//   hit_idx     : registered, index of the hit channel, 0 when no hit
// ---------------------------------------------------------------------------
module switch_indicator_bank #(
    parameter int N_CH         = 10,
    parameter int X1           = 0,
    parameter int Y1           = 0,
    parameter int SPACING      = 20,
    parameter int BOX_W        = 16,
    parameter int BOX_H        = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int CNT_W        = 5,
    parameter int BLINK_BIT    = 2,
    parameter int IDX_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic [0:N_CH-1]   status,
    input  logic [0:N_CH-1]   mask,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic              on_group,
    output logic              on_lit,
    output logic [IDX_W-1:0]  hit_idx
);

    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);

    logic [0:N_CH-1]  status_q, status_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic             on_group_q, on_group_d;
    logic             on_lit_q, on_lit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    logic [0:N_CH-1]  in_box;
    logic [0:N_CH-1]  visible;
    logic [0:N_CH-1]  hit;

    // Pixel coordinates are widened to 32-bit signed values. Box bounds are
    // elaboration-time ints, so neither side can wrap at the 10-bit edge.
    logic signed [31:0] px;
    logic signed [31:0] py;

    assign px = signed'({22'd0, x});
    assign py = signed'({22'd0, y});

    // Per-channel box geometry and visibility
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam int XL = X1 + SPACING * g;
        localparam int XH = XL + BOX_W - 1;
        localparam int YL = Y1;
        localparam int YH = Y1 + BOX_H - 1;

        assign in_box[g]  = (px >= XL) && (px <= XH) && (py >= YL) && (py <= YH);
        // A blinking channel shows only during the half-period when BLINK_BIT
        // is clear. An idle channel (count 0) is always shown.
        assign visible[g] = !mask[g] && ((cnt_q[g] == '0) || !cnt_q[g][BLINK_BIT]);
        assign hit[g]     = in_box[g] && visible[g];
    end

    // Frame-synchronous latch of switch state and blink counters.
    // A change reloads the counter, taking priority over the decrement.
    always_comb begin
        status_d = status_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (frame_tick) begin
            status_d = status;
            for (int i = 0; i < N_CH; i++) begin
                if (status[i] != status_q[i]) begin
                    cnt_d[i] = BLINK_LOAD;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Lowest-index hit wins when boxes overlap. The loop runs downward so
    // that the last assignment comes from the lowest index.
    always_comb begin
        on_group_d = 1'b0;
        on_lit_d   = 1'b0;
        hit_idx_d  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                on_group_d = 1'b1;
                on_lit_d   = status_q[i];
                hit_idx_d  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= '0;
            on_group_q <= 1'b0;
            on_lit_q   <= 1'b0;
            hit_idx_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            status_q   <= status_d;
            on_group_q <= on_group_d;
            on_lit_q   <= on_lit_d;
            hit_idx_q  <= hit_idx_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign on_group = on_group_q;
    assign on_lit   = on_lit_q;
    assign hit_idx  = hit_idx_q;

endmodule

// File: tb/tb_switch_indicator_bank.sv
// ---------------------------------------------------------------------------
// tb_switch_indicator_bank
//
// Self-checking bench for switch_indicator_bank with its default parameters:
// 10 channels, 16x16 boxes at a pitch of 20, and a blink of 30 frames on bit 2.
// Expected outputs are queued when stimulus is driven. They are popped and
// compared one cycle later, after the DUT edge.
// ---------------------------------------------------------------------------
module tb_switch_indicator_bank;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [0:9] status;
    logic [0:9] mask;
    logic [9:0] x;
    logic [9:0] y;
    logic       on_group;
    logic       on_lit;
    logic [3:0] hit_idx;

    switch_indicator_bank dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .status     (status),
        .mask       (mask),
        .x          (x),
        .y          (y),
        .on_group   (on_group),
        .on_lit     (on_lit),
        .hit_idx    (hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic       l;
        logic [3:0] i;
        string      nm;
    } exp_t;

    typedef struct {
        logic       tick;
        logic       g;
        logic       l;
        logic [3:0] i;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int checks = 0;
    int errors = 0;
    int m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle: queue its expectation, clock it, and compare the outputs.
    task automatic cyc(input logic tick, input logic eg, input logic el,
                       input logic [3:0] ei, input string nm);
        exp_t e;
        e.g  = eg;
        e.l  = el;
        e.i  = ei;
        e.nm = nm;
        sb.push_back(e);
        frame_tick = tick;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
        end else begin
            e = sb.pop_front();
            chk({e.nm, "_grp"}, 32'(on_group), 32'(e.g));
            chk({e.nm, "_lit"}, 32'(on_lit),   32'(e.l));
            chk({e.nm, "_idx"}, 32'(hit_idx),  32'(e.i));
        end
    endtask

    function automatic logic vis(input int c);
        return (c == 0) || (((c >> 2) & 1) == 0);
    endfunction

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        status     = '0;
        mask       = '0;
        x          = 10'd5;
        y          = 10'd5;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grp", 32'(on_group), 0);
        chk("rst_lit", 32'(on_lit), 0);
        chk("rst_idx", 32'(hit_idx), 0);
        chk("rst_cnt3", 32'(dut.cnt_q[3]), 0);
        reset = 1'b0;

        // Channel 0 box, all switches off
        cyc(1'b0, 1'b1, 1'b0, 4'd0, "ch0_basic");

        // Channel 3 turns on: the tick edge still sees the old state, then it blinks
        status[3] = 1'b1;
        x = 10'd65;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd3};  // tick: pre-update, cnt 0, status_q 0
        tbl[1] = '{1'b0, 1'b0, 1'b0, 4'd0};  // cnt 30 -> hidden
        tbl[2] = '{1'b1, 1'b0, 1'b0, 4'd0};  // cnt 30 -> 29
        tbl[3] = '{1'b1, 1'b0, 1'b0, 4'd0};  // cnt 29 -> 28
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0};  // cnt 28 -> 27
        tbl[5] = '{1'b0, 1'b1, 1'b1, 4'd3};  // cnt 27, bit 2 clear -> visible, lit
        for (int k = 0; k < 6; k++) begin
            cyc(tbl[k].tick, tbl[k].g, tbl[k].l, tbl[k].i, $sformatf("blink_v%0d", k));
            if (k == 0) chk("cnt3_load", 32'(dut.cnt_q[3]), 30);
        end
        chk("cnt3_27", 32'(dut.cnt_q[3]), 27);

        // Count down to 0, then check the count holds at 0 without wrapping
        m_cnt = 27;
        for (int k = 0; k < 27; k++) begin
            cyc(1'b1, vis(m_cnt), vis(m_cnt), vis(m_cnt) ? 4'd3 : 4'd0, "decay");
            m_cnt--;
        end
        chk("cnt3_zero", 32'(dut.cnt_q[3]), 0);
        cyc(1'b0, 1'b1, 1'b1, 4'd3, "idle_visible");
        cyc(1'b1, 1'b1, 1'b1, 4'd3, "tick31");
        chk("cnt3_nowrap", 32'(dut.cnt_q[3]), 0);

        // Toggle off, decay to 12, then toggle back on and reload
        status[3] = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 4'd3, "toggle_off");
        m_cnt = 30;
        chk("cnt3_reload_off", 32'(dut.cnt_q[3]), 30);
        for (int k = 0; k < 18; k++) begin
            cyc(1'b1, vis(m_cnt), 1'b0, vis(m_cnt) ? 4'd3 : 4'd0, "decay_off");
            m_cnt--;
        end
        chk("cnt3_12", 32'(dut.cnt_q[3]), 12);
        status[3] = 1'b1;
        cyc(1'b1, vis(12), 1'b0, 4'd0, "toggle_at12");
        chk("cnt3_reload12", 32'(dut.cnt_q[3]), 30);
        m_cnt = 30;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, vis(m_cnt), vis(m_cnt), vis(m_cnt) ? 4'd3 : 4'd0, "decay_on");
            m_cnt--;
        end
        chk("cnt3_20", 32'(dut.cnt_q[3]), 20);

        // Geometry: gap, far corner of channel 9, mask, just-outside edges
        x = 10'd76; y = 10'd5;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "gap76");
        x = 10'd195; y = 10'd15;
        cyc(1'b0, 1'b1, 1'b0, 4'd9, "ch9_corner");
        mask[9] = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "ch9_masked");
        mask[9] = 1'b0;
        x = 10'd196;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "ch9_right_out");
        x = 10'd195; y = 10'd16;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "ch9_below_out");
        x = 10'd180; y = 10'd0;
        cyc(1'b0, 1'b1, 1'b0, 4'd9, "ch9_topleft");

        // A status change without frame_tick is not latched
        status[3] = 1'b0;
        x = 10'd65; y = 10'd5;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "no_tick_hidden20");
        chk("status_q3_held", 32'(dut.status_q[3]), 1);
        chk("cnt3_held", 32'(dut.cnt_q[3]), 20);

        // Reset in the middle of a blink, with frame_tick high (ignored)
        x = 10'd5; y = 10'd5;
        reset = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        frame_tick = 1'b0;
        chk("midrst_grp", 32'(on_group), 0);
        chk("midrst_lit", 32'(on_lit), 0);
        chk("midrst_idx", 32'(hit_idx), 0);
        chk("midrst_cnt3", 32'(dut.cnt_q[3]), 0);
        chk("midrst_stat3", 32'(dut.status_q[3]), 0);

        // After reset, a status of 1 at the first tick is a fresh change
        status[3] = 1'b1;
        x = 10'd65;
        cyc(1'b1, 1'b1, 1'b0, 4'd3, "post_rst_tick");
        chk("post_rst_cnt3", 32'(dut.cnt_q[3]), 30);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, "post_rst_blink");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_indicator_bank.md
SWITCH_INDICATOR_BANK -- requirements
Module: switch_indicator_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 10: number of indicator channels (1..32).
REQ-002 The block SHALL have parameter X1, default 0: left pixel column of channel 0 box.
REQ-003 The block SHALL have parameter Y1, default 0: top pixel row of all boxes.
REQ-004 The block SHALL have parameter SPACING, default 20: horizontal pitch between channel boxes, in pixels.
REQ-005 The block SHALL have parameter BOX_W, default 16: box width in pixels.
REQ-006 The block SHALL have parameter BOX_H, default 16: box height in pixels.
REQ-007 The block SHALL have parameter BLINK_FRAMES, default 30: frames a channel blinks after a status change; must be < 2^CNT_W.
REQ-008 The block SHALL have parameter CNT_W, default 5: blink counter width.
REQ-009 The block SHALL have parameter BLINK_BIT, default 2: counter bit selecting blink phase; must be < CNT_W.
REQ-010 The block SHALL have parameter IDX_W, default 4: hit index width, >= clog2(N_CH).
REQ-011 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-012 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-013 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-014 The block SHALL have port status, input, [0:N_CH-1]: raw switch states, where status[i] drives channel i.
REQ-015 The block SHALL have port mask, input, [0:N_CH-1]: 1 hides channel i entirely.
REQ-016 The block SHALL have ports x and y, input, 10 bits each: current pixel coordinate.
REQ-017 The block SHALL have port on_group, output, 1 bit: pixel lies in a visible box (registered).
REQ-018 The block SHALL have port on_lit, output, 1 bit: pixel lies in a visible box whose latched status is 1 (registered).
REQ-019 The block SHALL have port hit_idx, output, IDX_W bits: index of the hit channel, 0 when there is no hit (registered).

Function
REQ-020 The block SHALL hold status_q[0:N_CH-1], which is loaded from status only on cycles with frame_tick=1 and is otherwise held, so indicators never tear mid-frame.
REQ-021 On frame_tick with status[i] != status_q[i], the block SHALL load cnt[i] with BLINK_FRAMES.
REQ-022 On frame_tick with no change on channel i and cnt[i] != 0, the block SHALL decrement cnt[i] by 1; cnt[i] holds at 0 and never wraps.
REQ-023 A change coinciding with a nonzero cnt[i] SHALL reload cnt[i] with BLINK_FRAMES; reload has priority over decrement.
REQ-024 Channel i SHALL be visible iff mask[i]=0 AND (cnt[i]=0 OR cnt[i][BLINK_BIT]=0); mask is combinational and takes effect immediately.
REQ-025 Channel i box SHALL cover columns X1+SPACING*i .. X1+SPACING*i+BOX_W-1 inclusive and rows Y1 .. Y1+BOX_H-1 inclusive; the block SHALL compute all bounds at elaboration, at least 11 bits wide, so no bound wraps.
REQ-026 Hit SHALL mean that (x,y) lies inside the box of a visible channel; if boxes overlap (SPACING < BOX_W), the lowest visible index SHALL win.
REQ-027 The block SHALL register on_group, on_lit and hit_idx: outputs reflect the x, y, mask, status_q and cnt present at rising edge k, and are valid from edge k onward (1-cycle latency).
REQ-028 With no hit, on_group=0, on_lit=0 and hit_idx=0.
REQ-029 A frame_tick and a pixel evaluation in the same cycle SHALL use pre-update status_q and cnt for the output computed at that edge.

Reset
REQ-030 While reset=1 at a rising edge, the block SHALL clear status_q, all cnt[i], on_group, on_lit and hit_idx to 0, and SHALL ignore frame_tick.
REQ-031 A reset asserted mid-blink SHALL terminate the blink; a channel whose status is 1 at the first post-reset frame_tick then blinks as a fresh change.

Verification
REQ-032 The bench SHALL cover: reset; x=5, y=5, status all 0, mask 0 -> after 1 clock on_group=1, on_lit=0, hit_idx=0.
REQ-033 The bench SHALL cover: status[3]=1 held across one frame_tick -> cnt[3]=30; pixel (65,5) -> on_group=0 (bit2 of 30 is 1); after 3 further ticks (cnt=27) -> on_group=1, on_lit=1, hit_idx=3.
REQ-034 The bench SHALL cover: 30 ticks after the change -> cnt[3]=0 and the box stays visible; a 31st tick -> cnt stays 0, no wrap.
REQ-035 The bench SHALL cover: status[3] toggling again while cnt[3]=12 -> cnt[3]=30 on that tick.
REQ-036 The bench SHALL cover: pixel (76,5) (gap) -> on_group=0; pixel (9*20+15, 15) -> hit_idx=9; mask[9]=1 at the same pixel -> on_group=0 on the next clock.
REQ-037 The bench SHALL cover: status changed without a frame_tick -> status_q, on_lit and cnt unchanged; reset asserted while cnt[3]=20 -> all outputs 0 and cnt[3]=0 next clock.
